// File: rtl/lbp_img_host.sv
// Memory-side responder for the LBP engine: loads an image from a host stream, serves
// zero-latency pixel reads, captures result writes and streams the result buffer out.
module lbp_img_host #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    input  logic [DATA_W-1:0]   load_data,
    output logic                load_ready,
    output logic                gray_ready,
    input  logic                gray_req,
    input  logic [ADDR_W-1:0]   gray_addr,
    output logic [DATA_W-1:0]   gray_data,
    input  logic                lbp_write,
    input  logic [ADDR_W-1:0]   lbp_addr,
    input  logic [DATA_W-1:0]   lbp_data,
    input  logic                finish,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic [ADDR_W:0]     wr_count,
    output logic                done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    // Handshakes: a byte/beat transfers on a rising edge where valid and ready are both high;
    // valid without ready is simply ignored, and ready never depends on valid.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] img [DEPTH];
    logic [DATA_W-1:0] res [DEPTH];
    logic [ADDR_W-1:0] ld_ptr;
    logic [ADDR_W-1:0] dp_ptr;

    logic load_hs, dump_hs, res_we;

    assign load_hs = (state == ST_LOAD) && load_valid;
    assign dump_hs = (state == ST_DUMP) && out_ready;
    assign res_we  = (state == ST_SERVE) && lbp_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (load_hs && ld_ptr == LAST_ADDR) state_nxt = ST_SERVE;
            ST_SERVE: if (finish) state_nxt = ST_DUMP;
            ST_DUMP:  if (dump_hs && dp_ptr == LAST_ADDR) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        load_ready = (state == ST_LOAD) && !reset;
        gray_ready = (state == ST_SERVE);
        gray_data  = '0;
        if (state == ST_SERVE && gray_req) gray_data = img[gray_addr];
        out_valid  = (state == ST_DUMP);
        out_data   = '0;
        out_last   = 1'b0;
        if (state == ST_DUMP) begin
            out_data = res[dp_ptr];
            out_last = (dp_ptr == LAST_ADDR);
        end
        done = (state == ST_DONE);
    end

    // Pointers wrap naturally on their final handshake, which is also the phase transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_ptr   <= '0;
            dp_ptr   <= '0;
            wr_count <= '0;
        end else begin
            if (load_hs) ld_ptr <= ld_ptr + 1'b1;
            if (dump_hs) dp_ptr <= dp_ptr + 1'b1;
            if (res_we && wr_count != {(ADDR_W+1){1'b1}}) wr_count <= wr_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) img[i] <= '0;
        end else if (load_hs) begin
            img[ld_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) res[i] <= '0;
        end else if (res_we) begin
            res[lbp_addr] <= lbp_data;
        end
    end

endmodule

// File: tb/tb_lbp_img_host.sv
// Directed bench for lbp_img_host: image load, pixel serving, result capture, stalled dump
// and reset in the middle of a dump.
module tb_lbp_img_host;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_ready;
    logic       gray_ready;
    logic       gray_req = 1'b0;
    logic [5:0] gray_addr = '0;
    logic [7:0] gray_data;
    logic       lbp_write = 1'b0;
    logic [5:0] lbp_addr = '0;
    logic [7:0] lbp_data = '0;
    logic       finish = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic [6:0] wr_count;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_res [64];

    lbp_img_host dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr),
        .gray_data(gray_data),
        .lbp_write(lbp_write), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
        .finish(finish),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .wr_count(wr_count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_load_ready", load_ready, 0);
        check("rst_gray_ready", gray_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_wr_count", wr_count, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("load_ready_after_rst", load_ready, 1);
    endtask

    // Loads 64 bytes with load_valid high every other cycle; inv selects 255-i instead of i.
    task automatic load_image(input bit inv);
        int  cnt = 0;
        int  cyc = 0;
        logic hs;
        while (cnt < 64 && cyc < 300) begin
            @(negedge clk);
            load_valid = cyc[0];
            load_data  = inv ? 8'(255 - cnt) : 8'(cnt);
            #1;
            if (cnt == 63 && load_valid) check("gray_ready_before_last", gray_ready, 0);
            hs = load_valid && load_ready;
            @(posedge clk);
            if (hs) cnt++;
            cyc++;
        end
        #1;
        load_valid = 1'b0;
        check("load_count", cnt, 64);
        check("gray_ready_after_load", gray_ready, 1);
        // A further byte must be refused and must not disturb img[0].
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hEE;
        #1;
        check("load_ready_in_serve", load_ready, 0);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic gray_read(input logic [5:0] addr, input logic [7:0] exp, input string tag);
        @(negedge clk);
        gray_req  = 1'b1;
        gray_addr = addr;
        #1;
        check(tag, gray_data, exp);
        gray_req = 1'b0;
        #1;
        check("gray_req_low", gray_data, 0);
    endtask

    task automatic drive_cycle(input bit wr, input logic [5:0] addr, input logic [7:0] data,
                               input bit fin);
        @(negedge clk);
        lbp_write = wr;
        lbp_addr  = addr;
        lbp_data  = data;
        finish    = fin;
        @(posedge clk);
        #1;
        lbp_write = 1'b0;
        finish    = 1'b0;
    endtask

    task automatic fill_exp_q();
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(exp_res[i]);
    endtask

    // Drains the dump; stalls 5 cycles at stall_beat (with a stray lbp_write), or asserts
    // reset when reaching reset_beat and returns with reset still high.
    task automatic dump(input int stall_beat, input int reset_beat);
        int   beat = 0;
        int   cyc = 0;
        int   lasts = 0;
        int   stall_left = 5;
        logic stalling, hs, is_last;
        while (beat < 64 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (beat == reset_beat) begin
                reset     = 1'b1;
                out_ready = 1'b0;
                #1;
                check("mid_rst_out_valid", out_valid, 0);
                check("mid_rst_load_ready", load_ready, 0);
                check("mid_rst_gray_ready", gray_ready, 0);
                return;
            end
            stalling  = (beat == stall_beat) && (stall_left > 0);
            out_ready = !stalling;
            lbp_write = stalling;
            lbp_addr  = 6'd11;
            lbp_data  = 8'hFF;
            #1;
            check("dump_valid", out_valid, 1);
            check($sformatf("dump_data_%0d", beat), out_data, exp_q[0]);
            check($sformatf("dump_last_%0d", beat), out_last, (beat == 63));
            if (stalling) stall_left--;
            hs      = out_valid && out_ready;
            is_last = out_last;
            @(posedge clk);
            if (hs) begin
                void'(exp_q.pop_front());
                beat++;
                if (is_last) lasts++;
            end
        end
        #1;
        lbp_write = 1'b0;
        out_ready = 1'b0;
        check("dump_beats", beat, 64);
        check("dump_last_count", lasts, 1);
        check("dump_valid_drop", out_valid, 0);
        check("done_high", done, 1);
    endtask

    initial begin
        // Run A: ramp image, overwrite of one result, plain dump.
        apply_reset();
        gray_read(6'd0, 8'd0, "gray_in_load");
        drive_cycle(1'b1, 6'd5, 8'hFF, 1'b1);
        check("wr_ignored_in_load", wr_count, 0);
        check("finish_ignored_in_load", load_ready, 1);
        load_image(1'b0);
        gray_read(6'd9, 8'd9, "gray_9");
        gray_read(6'd63, 8'd63, "gray_63");
        gray_read(6'd0, 8'd0, "gray_0_not_ee");
        gray_read(6'd5, 8'd5, "gray_5");
        drive_cycle(1'b1, 6'd9, 8'hA5, 1'b0);
        drive_cycle(1'b1, 6'd9, 8'h3C, 1'b0);
        check("wr_count_2", wr_count, 2);
        drive_cycle(1'b0, 6'd0, 8'h00, 1'b1);
        for (int i = 0; i < 64; i++) exp_res[i] = 8'h00;
        exp_res[9] = 8'h3C;
        fill_exp_q();
        dump(-1, -1);
        drive_cycle(1'b1, 6'd3, 8'h77, 1'b1);
        check("wr_ignored_in_done", wr_count, 2);
        check("done_hold", done, 1);
        check("load_ready_done", load_ready, 0);
        check("gray_ready_done", gray_ready, 0);
        gray_read(6'd9, 8'd0, "gray_in_done");

        // Run B: interior-only writes like an engine run, last write coincides with finish.
        apply_reset();
        load_image(1'b0);
        for (int i = 0; i < 64; i++) exp_res[i] = 8'h00;
        for (int y = 1; y <= 6; y++) begin
            for (int x = 1; x <= 6; x++) begin
                drive_cycle(1'b1, 6'(y * 8 + x), 8'(y * 8 + x) ^ 8'h5A, (y == 6 && x == 6));
                exp_res[y * 8 + x] = 8'(y * 8 + x) ^ 8'h5A;
            end
        end
        check("wr_count_36", wr_count, 36);
        check("dump_entered", out_valid, 1);
        fill_exp_q();
        dump(10, -1);
        check("wr_count_after_dump", wr_count, 36);

        // Run C: reset during beat 20, then a fresh run must not show old results.
        apply_reset();
        load_image(1'b0);
        drive_cycle(1'b1, 6'd20, 8'h77, 1'b1);
        for (int i = 0; i < 64; i++) exp_res[i] = 8'h00;
        exp_res[20] = 8'h77;
        fill_exp_q();
        dump(-1, 20);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("load_ready_after_mid_rst", load_ready, 1);
        check("wr_count_after_mid_rst", wr_count, 0);
        load_image(1'b1);
        gray_read(6'd9, 8'd246, "gray_inv_9");
        gray_read(6'd63, 8'd192, "gray_inv_63");
        drive_cycle(1'b1, 6'd9, 8'h11, 1'b0);
        drive_cycle(1'b0, 6'd0, 8'h00, 1'b1);
        check("wr_count_1", wr_count, 1);
        for (int i = 0; i < 64; i++) exp_res[i] = 8'h00;
        exp_res[9] = 8'h11;
        fill_exp_q();
        dump(-1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
